// File: rtl/lfsr_offset_finder_pkg.sv
// Shared LFSR definitions: state width, lighthouse polynomials and the single step function
// used by both the sequence generator and the offset finder.
`timescale 1ns/1ps
package lfsr_offset_finder_pkg;

  localparam int LFSR_WIDTH    = 17;
  localparam int LFSR_MAX_ITER = 131071;

  localparam logic [LFSR_WIDTH-1:0] POLY_LH0 = 17'h1d258;
  localparam logic [LFSR_WIDTH-1:0] POLY_LH1 = 17'h17e04;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SEARCH = 1'b1
  } finder_state_e;

  // Fibonacci-style step: parity of tapped bits shifts in at the LSB.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_step(
    input logic [LFSR_WIDTH-1:0] state,
    input logic [LFSR_WIDTH-1:0] polynomial
  );
    return {state[LFSR_WIDTH-2:0], ^(state & polynomial)};
  endfunction

endpackage

// File: rtl/lfsr_offset_finder.sv
// Brute-force inverse of the LFSR generator: steps from the seed once per clock until the
// captured target appears, reporting its offset, or gives up after MAX_ITER steps.
`timescale 1ns/1ps
module lfsr_offset_finder
  import lfsr_offset_finder_pkg::*;
#(
  parameter int WIDTH    = LFSR_WIDTH,
  parameter int MAX_ITER = LFSR_MAX_ITER
) (
  input  logic             clk_96MHz,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] polynomial,
  input  logic [WIDTH-1:0] start_data,
  input  logic [WIDTH-1:0] target,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] iteration_number
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_ITER);

  finder_state_e    fsm_r, fsm_s;
  logic [WIDTH-1:0] lfsr_r, lfsr_s;
  logic [WIDTH-1:0] count_r, count_s;
  logic [WIDTH-1:0] poly_r, poly_s;
  logic [WIDTH-1:0] target_r, target_s;
  logic             done_s;
  logic             found_s;
  logic [WIDTH-1:0] iter_s;

  // Next-state and result logic; abort outranks a match, a match outranks exhaustion.
  always_comb begin
    fsm_s    = fsm_r;
    lfsr_s   = lfsr_r;
    count_s  = count_r;
    poly_s   = poly_r;
    target_s = target_r;
    done_s   = 1'b0;
    found_s  = found;
    iter_s   = iteration_number;
    case (fsm_r)
      ST_IDLE: begin
        if (start) begin
          poly_s   = polynomial;
          target_s = target;
          lfsr_s   = start_data;
          count_s  = {WIDTH{1'b0}};
          found_s  = 1'b0;
          iter_s   = {WIDTH{1'b0}};
          fsm_s    = ST_SEARCH;
        end else begin
          fsm_s    = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        if (abort) begin
          fsm_s   = ST_IDLE;
        end else if (lfsr_r == target_r) begin
          done_s  = 1'b1;
          found_s = 1'b1;
          iter_s  = count_r;
          fsm_s   = ST_IDLE;
        end else if (count_r == MAX_CNT) begin
          done_s  = 1'b1;
          found_s = 1'b0;
          iter_s  = MAX_CNT;
          fsm_s   = ST_IDLE;
        end else begin
          lfsr_s  = lfsr_step(lfsr_r, poly_r);
          count_s = count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        fsm_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; busy mirrors the next FSM state.
  always_ff @(posedge clk_96MHz or posedge reset) begin
    if (reset) begin
      fsm_r            <= ST_IDLE;
      lfsr_r           <= {WIDTH{1'b0}};
      count_r          <= {WIDTH{1'b0}};
      poly_r           <= {WIDTH{1'b0}};
      target_r         <= {WIDTH{1'b0}};
      busy             <= 1'b0;
      done             <= 1'b0;
      found            <= 1'b0;
      iteration_number <= {WIDTH{1'b0}};
    end else begin
      fsm_r            <= fsm_s;
      lfsr_r           <= lfsr_s;
      count_r          <= count_s;
      poly_r           <= poly_s;
      target_r         <= target_s;
      busy             <= (fsm_s == ST_SEARCH);
      done             <= done_s;
      found            <= found_s;
      iteration_number <= iter_s;
    end
  end

endmodule
